// File: rtl/cpu_scoreboard_pkg.sv
// Shared definitions for the CPU write-side hazard scoreboard.
//   - Register-file geometry and per-register in-flight limit.
//   - Drain FSM state encodings.
//   - Opcode classification helpers. L-class opcodes read src1 only.
//     R-class opcodes read both src1 and src2.
package cpu_scoreboard_pkg;

  localparam int NUM_REGS     = 16;
  localparam int REG_W        = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 3;

  // Drain FSM states. Kept as plain constants so older tools see the same encoding.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef logic [1:0] sb_state_t;

  // Opcodes that read src1 only.
  localparam logic [7:0] OP_L0 = 8'h11;
  localparam logic [7:0] OP_L1 = 8'h13;
  localparam logic [7:0] OP_L2 = 8'h15;
  localparam logic [7:0] OP_L3 = 8'h23;
  localparam logic [7:0] OP_L4 = 8'h25;
  localparam logic [7:0] OP_L5 = 8'h27;
  localparam logic [7:0] OP_L6 = 8'h85;
  localparam logic [7:0] OP_L7 = 8'h87;

  // Opcodes that read src1 and src2.
  localparam logic [7:0] OP_R0 = 8'h10;
  localparam logic [7:0] OP_R1 = 8'h12;
  localparam logic [7:0] OP_R2 = 8'h14;
  localparam logic [7:0] OP_R3 = 8'h16;
  localparam logic [7:0] OP_R4 = 8'h20;
  localparam logic [7:0] OP_R5 = 8'h22;
  localparam logic [7:0] OP_R6 = 8'h24;

  function automatic logic is_l_type(input logic [7:0] opcode);
    case (opcode)
      OP_L0, OP_L1, OP_L2, OP_L3, OP_L4, OP_L5, OP_L6, OP_L7: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic is_r_type(input logic [7:0] opcode);
    case (opcode)
      OP_R0, OP_R1, OP_R2, OP_R3, OP_R4, OP_R5, OP_R6: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_scoreboard_if.sv
// Signal bundle between the pipeline control and the scoreboard.
//
// The master modport is the pipeline side. It drives:
//   - fetch instruction
//   - issue strobe and destination register
//   - writeback strobe and destination register
//   - flush
//   - drain request
//
// The slave modport is the scoreboard side. It returns:
//   - hazard stall
//   - pending mask
//   - drain status
//   - sticky error flags
interface cpu_scoreboard_if;
  import cpu_scoreboard_pkg::*;

  logic [31:0]         if_instr;
  logic                issue_en;
  logic [REG_W-1:0]    issue_reg;
  logic                wb_en;
  logic [REG_W-1:0]    wb_reg;
  logic                flush;
  logic                drain_req;
  logic                rw_stall;
  logic [NUM_REGS-1:0] pending_mask;
  logic                drain_busy;
  logic                drain_done;
  logic                err_ovf;
  logic                err_unf;

  modport master (
    output if_instr, issue_en, issue_reg, wb_en, wb_reg, flush, drain_req,
    input  rw_stall, pending_mask, drain_busy, drain_done, err_ovf, err_unf
  );

  modport slave (
    input  if_instr, issue_en, issue_reg, wb_en, wb_reg, flush, drain_req,
    output rw_stall, pending_mask, drain_busy, drain_done, err_ovf, err_unf
  );

endinterface

// File: rtl/cpu_scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       zero the count; inc/dec in the same cycle are ignored
//   inc         a write to this register issued
//   dec         a write to this register retired
//   nonzero     count != 0
//   ovf         sticky: inc while the count is at MAX_INFLIGHT
//   unf         sticky: dec while the count is 0
module cpu_sb_counter #(
  parameter int CNT_W        = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf,
  output logic unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so that every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (cnt == CNT_MAX) ovf <= 1'b1;
          else                cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt == '0) unf <= 1'b1;
          else           cnt <= cnt - 1'b1;
        end
        default: ; // idle, or issue and retire cancel each other
      endcase
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/cpu_scoreboard.sv
// Write-side hazard tracker for the 5-stage CPU.
//
// Every register write is counted when it issues from decode and uncounted when it retires at writeback.
// rw_stall flags a read-after-write hazard for the instruction in fetch.
// It is computed from the registered pending mask only.
// A drain handshake (RUN -> DRAIN -> DONE -> RUN) lets branch control wait until no writes are in flight.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         cpu_scoreboard_if.slave; the instruction/issue/writeback/flush/drain inputs and the
//               stall/pending/drain/error outputs
module cpu_scoreboard
  import cpu_scoreboard_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  cpu_scoreboard_if.slave bus
);

  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] ovf_vec;
  logic [NUM_REGS-1:0] unf_vec;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    cpu_sb_counter #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (bus.flush),
      .inc     (bus.issue_en && (bus.issue_reg == REG_W'(r))),
      .dec     (bus.wb_en    && (bus.wb_reg    == REG_W'(r))),
      .nonzero (nonzero[r]),
      .ovf     (ovf_vec[r]),
      .unf     (unf_vec[r])
    );
  end

  assign bus.pending_mask = nonzero;
  assign bus.err_ovf      = |ovf_vec;
  assign bus.err_unf      = |unf_vec;

  // Hazard decode. It looks only at registered counters. A write retiring this cycle therefore still
  // stalls its reader, and a write issuing this cycle does not stall yet.
  logic [7:0]       opcode;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             stall;
  logic             unused_instr_bits;

  assign opcode            = bus.if_instr[31:24];
  assign src1              = bus.if_instr[19:16];
  assign src2              = bus.if_instr[15:12];
  assign unused_instr_bits = ^{bus.if_instr[23:20], bus.if_instr[11:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stall = 1'b0;
    if (is_l_type(opcode))      stall = nonzero[src1];
    else if (is_r_type(opcode)) stall = nonzero[src1] | nonzero[src2];
  end

  assign bus.rw_stall = stall;

  // Drain FSM. DRAIN is always visited, even with nothing pending, so that drain_done always arrives
  // exactly two cycles or more after the request.
  sb_state_t state;
  sb_state_t state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (bus.drain_req)            state_nxt = ST_DRAIN;
      ST_DRAIN: if (bus.pending_mask == '0)   state_nxt = ST_DONE;
      ST_DONE:                                state_nxt = ST_RUN;
      default:                                state_nxt = ST_RUN;
    endcase
    if (bus.flush) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  assign bus.drain_busy = (state == ST_DRAIN);
  assign bus.drain_done = (state == ST_DONE);

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed-vector bench for cpu_scoreboard.
// Each tick drives one cycle of inputs and queues the full output vector expected during that cycle.
// A monitor compares the queued vector against the DUT on the falling edge.
module tb_cpu_scoreboard;
  import cpu_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_scoreboard_if sb_if ();

  cpu_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if.slave)
  );

  // {rw_stall, pending_mask[15:0], drain_busy, drain_done, err_ovf, err_unf}
  typedef struct {
    string       name;
    logic [20:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Inputs staged for the next tick; cleared after each tick.
  logic [31:0]      s_instr;
  logic             s_ie, s_we, s_fl, s_dr, s_rst;
  logic [REG_W-1:0] s_ir, s_wr;

  function automatic logic [20:0] ev(input logic st, input logic [15:0] m, input logic b,
                                     input logic d, input logic o, input logic u);
    return {st, m, b, d, o, u};
  endfunction

  task automatic clear_stage();
    s_instr = 32'h0; s_ie = 1'b0; s_ir = '0; s_we = 1'b0; s_wr = '0;
    s_fl = 1'b0; s_dr = 1'b0; s_rst = 1'b1;
  endtask

  task automatic tick(input string name, input logic [20:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n             = s_rst;
    sb_if.if_instr    = s_instr;
    sb_if.issue_en    = s_ie;
    sb_if.issue_reg   = s_ir;
    sb_if.wb_en       = s_we;
    sb_if.wb_reg      = s_wr;
    sb_if.flush       = s_fl;
    sb_if.drain_req   = s_dr;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
    clear_stage();
  endtask

  // Monitor: compare every queued expectation half a cycle after it was issued.
  initial begin
    exp_t        e;
    logic [20:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {sb_if.rw_stall, sb_if.pending_mask, sb_if.drain_busy,
               sb_if.drain_done, sb_if.err_ovf, sb_if.err_unf};
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got stall=%b mask=%h busy=%b done=%b ovf=%b unf=%b, expected stall=%b mask=%h busy=%b done=%b ovf=%b unf=%b",
                   e.name, act[20], act[19:4], act[3], act[2], act[1], act[0],
                   e.exp[20], e.exp[19:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    sb_if.if_instr = 32'h0; sb_if.issue_en = 1'b0; sb_if.issue_reg = '0;
    sb_if.wb_en = 1'b0; sb_if.wb_reg = '0; sb_if.flush = 1'b0; sb_if.drain_req = 1'b0;
    clear_stage();

    // 1: reset
    s_rst = 1'b0;                                   tick("reset", ev(0, 16'h0000, 0, 0, 0, 0));

    // 2: L-type hazard on r3, no retire bypass
    s_ie = 1; s_ir = 4'd3;                          tick("issue_r3", ev(0, 16'h0000, 0, 0, 0, 0));
    s_instr = 32'h1103_0000; s_we = 1; s_wr = 4'd3; tick("l_stall_r3", ev(1, 16'h0008, 0, 0, 0, 0));
    s_instr = 32'h1103_0000;                        tick("l_clear_r3", ev(0, 16'h0000, 0, 0, 0, 0));

    // 3: R-type reads src2, non-reader opcode, L-type ignores src2
    s_ie = 1; s_ir = 4'd5;                          tick("issue_r5", ev(0, 16'h0000, 0, 0, 0, 0));
    s_instr = 32'h1001_5000;                        tick("r_stall_src2", ev(1, 16'h0020, 0, 0, 0, 0));
    s_instr = 32'h3001_5000;                        tick("op30_nostall", ev(0, 16'h0020, 0, 0, 0, 0));
    s_instr = 32'h1101_5000; s_we = 1; s_wr = 4'd5; tick("l_ignores_src2", ev(0, 16'h0020, 0, 0, 0, 0));

    // 4: simultaneous issue+retire, then saturation at MAX_INFLIGHT
    s_ie = 1; s_ir = 4'd7;                          tick("issue_r7", ev(0, 16'h0000, 0, 0, 0, 0));
    s_ie = 1; s_ir = 4'd7; s_we = 1; s_wr = 4'd7;   tick("r7_inc_dec", ev(0, 16'h0080, 0, 0, 0, 0));
    s_we = 1; s_wr = 4'd7;                          tick("r7_held_1", ev(0, 16'h0080, 0, 0, 0, 0));
    s_ie = 1; s_ir = 4'd2;                          tick("r2_issue1", ev(0, 16'h0000, 0, 0, 0, 0));
    for (int i = 2; i <= 5; i++) begin
      s_ie = 1; s_ir = 4'd2;                        tick($sformatf("r2_issue%0d", i), ev(0, 16'h0004, 0, 0, 0, 0));
    end
    for (int i = 1; i <= 4; i++) begin
      s_we = 1; s_wr = 4'd2;                        tick($sformatf("r2_wb%0d", i), ev(0, 16'h0004, 0, 0, 1, 0));
    end

    // 5: underflow on r9; sticky through flush, cleared only by reset
    s_we = 1; s_wr = 4'd9;                          tick("r2_empty_wb_r9", ev(0, 16'h0000, 0, 0, 1, 0));
    s_fl = 1; s_ie = 1; s_ir = 4'd1; s_we = 1; s_wr = 4'd3;
                                                    tick("unf_set", ev(0, 16'h0000, 0, 0, 1, 1));
    tick("flush_ignores_io", ev(0, 16'h0000, 0, 0, 1, 1));
    s_rst = 1'b0;                                   tick("reset_clears_err", ev(0, 16'h0000, 0, 0, 0, 0));

    // 6: drain waits for r4, done pulse, drain_req ignored in DONE, flush
    s_ie = 1; s_ir = 4'd4;                          tick("issue_r4", ev(0, 16'h0000, 0, 0, 0, 0));
    s_dr = 1;                                       tick("drain_req", ev(0, 16'h0010, 0, 0, 0, 0));
    tick("drain_wait", ev(0, 16'h0010, 1, 0, 0, 0));
    s_we = 1; s_wr = 4'd4;                          tick("drain_wb_r4", ev(0, 16'h0010, 1, 0, 0, 0));
    tick("drain_last", ev(0, 16'h0000, 1, 0, 0, 0));
    s_dr = 1;                                       tick("drain_done", ev(0, 16'h0000, 0, 1, 0, 0));
    s_ie = 1; s_ir = 4'd6;                          tick("done_one_cycle", ev(0, 16'h0000, 0, 0, 0, 0));
    s_fl = 1;                                       tick("pre_flush", ev(0, 16'h0040, 0, 0, 0, 0));
    s_dr = 1;                                       tick("post_flush", ev(0, 16'h0000, 0, 0, 0, 0));
    tick("empty_drain", ev(0, 16'h0000, 1, 0, 0, 0));
    tick("empty_done", ev(0, 16'h0000, 0, 1, 0, 0));
    s_ie = 1; s_ir = 4'd0;                          tick("back_run", ev(0, 16'h0000, 0, 0, 0, 0));

    // mid-drain async reset: no done pulse afterwards
    s_dr = 1;                                       tick("drain_req_r0", ev(0, 16'h0001, 0, 0, 0, 0));
    tick("drain_busy_r0", ev(0, 16'h0001, 1, 0, 0, 0));
    s_rst = 1'b0;                                   tick("async_reset", ev(0, 16'h0000, 0, 0, 0, 0));
    tick("after_reset", ev(0, 16'h0000, 0, 0, 0, 0));
    tick("no_done", ev(0, 16'h0000, 0, 0, 0, 0));

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_queue: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
